// File: rtl/align_lock_ctrl.sv
// Link alignment lock controller: drives the channel aligner reset, hunts for the sync
// word, declares lock and supervises it window by window, re-aligning when lock is lost.
module align_lock_ctrl #(
   parameter logic [15:0] SYNC_PATTERN   = 16'h817E,
   parameter int          RST_CYCLES     = 8,
   parameter int          SEARCH_TIMEOUT = 4096,
   parameter int          MIN_SYNC       = 2,
   parameter int          WINDOW         = 64,
   parameter int          MAX_BAD        = 4
) (
   input  logic        clk,
   input  logic        reset_n,
   input  logic        enable,
   input  logic        valid_in,
   input  logic [15:0] data_in,
   output logic        align_rst,
   output logic        locked,
   output logic [1:0]  state_o,
   output logic [7:0]  relock_count,
   output logic        valid_o,
   output logic [15:0] data_o
);

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_RST    = 2'd1,
      ST_SEARCH = 2'd2,
      ST_LOCKED = 2'd3
   } state_t;

   localparam logic [7:0]  RST_LAST     = 8'(RST_CYCLES - 1);
   localparam logic [15:0] TIMEOUT_LAST = 16'(SEARCH_TIMEOUT - 1);
   localparam logic [15:0] SYNC_MIN     = 16'(MIN_SYNC);
   localparam logic [15:0] WIN_LEN      = 16'(WINDOW);
   localparam logic [7:0]  BAD_MAX      = 8'(MAX_BAD);

   state_t      r_state;
   logic [1:0]  r_rstSync;
   logic [7:0]  r_rstCnt;
   logic [15:0] r_timer;
   logic [15:0] r_syncCnt;
   logic [15:0] r_winWords;
   logic [15:0] r_winSync;
   logic [7:0]  r_badCnt;
   logic        r_alignRst;
   logic        r_locked;
   logic [7:0]  r_relock;
   logic        r_validO;
   logic [15:0] r_dataO;

   logic        w_runOk;
   logic        w_syncWord;
   logic [15:0] w_syncNext;
   logic [15:0] w_winWordsNext;
   logic [15:0] w_winSyncNext;
   logic        w_windowEnd;
   logic        w_windowBad;
   logic [7:0]  w_badNext;
   logic [7:0]  w_relockInc;

   // Reset release is only honoured once it has passed through two flops in the clk domain.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_rstSync <= 2'b00;
      end else begin
         r_rstSync <= {r_rstSync[0], 1'b1};
      end
   end

   always_comb begin
      w_runOk        = r_rstSync[1];
      w_syncWord     = valid_in && (data_in == SYNC_PATTERN);
      w_syncNext     = r_syncCnt + 16'(w_syncWord);
      w_winWordsNext = r_winWords + 16'(valid_in);
      w_winSyncNext  = r_winSync + 16'(w_syncWord);
      w_windowEnd    = valid_in && (w_winWordsNext == WIN_LEN);
      w_windowBad    = (w_winSyncNext < SYNC_MIN);
      w_badNext      = r_badCnt + 8'd1;
      w_relockInc    = (r_relock == 8'hFF) ? r_relock : r_relock + 8'd1;
   end

   // Lock wins over timeout in SEARCH; a sync on the window-closing word counts for that window.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_state    <= ST_IDLE;
         r_rstCnt   <= 8'd0;
         r_timer    <= 16'd0;
         r_syncCnt  <= 16'd0;
         r_winWords <= 16'd0;
         r_winSync  <= 16'd0;
         r_badCnt   <= 8'd0;
         r_alignRst <= 1'b1;
         r_locked   <= 1'b0;
         r_relock   <= 8'd0;
         r_validO   <= 1'b0;
         r_dataO    <= 16'd0;
      end else begin
         r_validO <= valid_in && (r_state == ST_LOCKED);
         r_dataO  <= data_in;
         if (!enable) begin
            r_state    <= ST_IDLE;
            r_alignRst <= 1'b1;
            r_locked   <= 1'b0;
            r_rstCnt   <= 8'd0;
            r_timer    <= 16'd0;
            r_syncCnt  <= 16'd0;
            r_winWords <= 16'd0;
            r_winSync  <= 16'd0;
            r_badCnt   <= 8'd0;
         end else begin
            case (r_state)
               ST_IDLE: begin
                  r_alignRst <= 1'b1;
                  r_locked   <= 1'b0;
                  if (w_runOk) begin
                     r_state  <= ST_RST;
                     r_rstCnt <= 8'd0;
                  end
               end
               ST_RST: begin
                  if (r_rstCnt == RST_LAST) begin
                     r_state    <= ST_SEARCH;
                     r_alignRst <= 1'b0;
                     r_timer    <= 16'd0;
                     r_syncCnt  <= 16'd0;
                  end else begin
                     r_rstCnt <= r_rstCnt + 8'd1;
                  end
               end
               ST_SEARCH: begin
                  if (w_syncNext >= SYNC_MIN) begin
                     r_state    <= ST_LOCKED;
                     r_locked   <= 1'b1;
                     r_winWords <= 16'd0;
                     r_winSync  <= 16'd0;
                     r_badCnt   <= 8'd0;
                  end else if (r_timer == TIMEOUT_LAST) begin
                     r_state    <= ST_RST;
                     r_alignRst <= 1'b1;
                     r_rstCnt   <= 8'd0;
                     r_relock   <= w_relockInc;
                  end else begin
                     r_timer   <= r_timer + 16'd1;
                     r_syncCnt <= w_syncNext;
                  end
               end
               ST_LOCKED: begin
                  if (w_windowEnd) begin
                     r_winWords <= 16'd0;
                     r_winSync  <= 16'd0;
                     if (!w_windowBad) begin
                        r_badCnt <= 8'd0;
                     end else if (w_badNext == BAD_MAX) begin
                        r_state    <= ST_RST;
                        r_locked   <= 1'b0;
                        r_alignRst <= 1'b1;
                        r_rstCnt   <= 8'd0;
                        r_badCnt   <= 8'd0;
                        r_relock   <= w_relockInc;
                     end else begin
                        r_badCnt <= w_badNext;
                     end
                  end else if (valid_in) begin
                     r_winWords <= w_winWordsNext;
                     r_winSync  <= w_winSyncNext;
                  end
               end
               default: begin
                  r_state <= ST_IDLE;
               end
            endcase
         end
      end
   end

   assign align_rst    = r_alignRst;
   assign locked       = r_locked;
   assign state_o      = r_state;
   assign relock_count = r_relock;
   assign valid_o      = r_validO;
   assign data_o       = r_dataO;

endmodule

// File: doc/align_lock_ctrl.md
ALIGN_LOCK_CTRL -- requirements
Module: align_lock_ctrl

Interface
REQ-001 Parameter SYNC_PATTERN, default 16'h817E, is the sync word matched on the aligned stream.
REQ-002 Parameter RST_CYCLES, default 8, is the aligner reset pulse length in clk cycles (range 1..255).
REQ-003 Parameter SEARCH_TIMEOUT, default 4096, is the number of SEARCH cycles before forced re-align (range 1..65535).
REQ-004 Parameter MIN_SYNC, default 2, is the minimum count of sync words needed to acquire lock and to pass a window.
REQ-005 Parameter WINDOW, default 64, is the number of valid words per monitoring window in LOCKED.
REQ-006 Parameter MAX_BAD, default 4, is the number of consecutive failed windows that drops lock.
REQ-007 clk  input  1  single clock; all logic rising-edge.
REQ-008 reset_n  input  1  asynchronous, active-low reset.
REQ-009 enable  input  1  level; 1 runs the controller, 0 forces IDLE.
REQ-010 valid_in  input  1  aligner output word valid.
REQ-011 data_in  input  16  aligner output word.
REQ-012 align_rst  output  1  active-high synchronous reset to the channel aligner.
REQ-013 locked  output  1  link locked status.
REQ-014 state_o  output  2  current state: 0 IDLE, 1 RST, 2 SEARCH, 3 LOCKED.
REQ-015 relock_count  output  8  number of lock losses plus search timeouts, saturating.
REQ-016 valid_o  output  1  valid_in gated by locked, registered.
REQ-017 data_o  output  16  data_in, registered.

Function
REQ-018 All outputs SHALL be registered; "sync word" means valid_in=1 and data_in==SYNC_PATTERN in the same cycle.
REQ-019 IDLE: align_rst=1, locked=0; enable=1 -> RST next cycle.
REQ-020 RST: align_rst=1 for exactly RST_CYCLES cycles counted from entry, then SEARCH with align_rst=0 on the first SEARCH cycle.
REQ-021 SEARCH: timer and sync counter cleared on entry; timer increments every cycle; sync counter increments on each sync word (non-consecutive allowed).
REQ-022 SEARCH -> LOCKED on the cycle the sync counter reaches MIN_SYNC; locked=1 from the first LOCKED cycle.
REQ-023 SEARCH -> RST when timer reaches SEARCH_TIMEOUT-1 without lock; relock_count increments; if lock and timeout coincide, lock wins.
REQ-024 LOCKED: window word counter counts valid_in=1 cycles; window sync counter counts sync words; both cleared on LOCKED entry and at every window end.
REQ-025 Window end is the cycle carrying the WINDOW-th valid word; a sync word on that cycle SHALL count toward the closing window.
REQ-026 At window end: sync count < MIN_SYNC -> bad counter +1, else bad counter cleared.
REQ-027 Bad counter reaching MAX_BAD -> RST next cycle, locked=0, relock_count +1, bad counter cleared.
REQ-028 relock_count SHALL saturate at 255 and clear only on reset.
REQ-029 enable=0 in any state -> IDLE next cycle, overriding all other transitions; counters cleared; relock_count retained.
REQ-030 valid_o = registered (valid_in AND state==LOCKED); data_o = registered data_in; latency 1 cycle.
REQ-031 valid_in=0 cycles SHALL NOT advance window counters and SHALL NOT count as sync words.

Reset
REQ-032 reset_n=0 SHALL asynchronously set state IDLE, align_rst=1, locked=0, valid_o=0, data_o=0, relock_count=0, all internal counters 0.
REQ-033 reset_n deassertion SHALL be synchronised internally (2-flop) before the FSM leaves IDLE.
REQ-034 Reset asserted mid-RST, mid-SEARCH or mid-LOCKED SHALL return to the REQ-032 state with no relock_count increment.

Verification
REQ-035 enable=1, sync word every 8th valid cycle -> align_rst high 8 cycles, SEARCH, locked=1 after 2nd sync word, valid_o follows valid_in with 1-cycle latency.
REQ-036 Locked, then sync words stop -> exactly 4 windows of 64 valid words later locked=0, align_rst high 8 cycles, relock_count=1.
REQ-037 SEARCH with no sync words -> RST entered after 4096 SEARCH cycles, relock_count=1; repeated 300 times -> relock_count=255.
REQ-038 Locked, 3 bad windows then 1 good window then 3 bad -> locked stays 1 (bad counter cleared).
REQ-039 Sync word on the 64th valid word with only 1 prior sync in window -> window passes; enable dropped same cycle as timeout -> IDLE, relock_count unchanged.
REQ-040 reset_n pulsed low while LOCKED -> outputs at REQ-032 values immediately, relock_count=0.
